// File: rtl/gb_oam_dma.sv
// rtl/gb_oam_dma.sv - OAM DMA engine copying p_LEN bytes from {src_page,8'h00} to p_DST_BASE
// Optional restart-while-busy behaviour: define DMG_DMA_RESTART_EN.
module gb_oam_dma #(
  parameter int p_ADDR_BITS = 16,
  parameter int p_DATA_BITS = 8,
  parameter int p_LEN       = 160,
  parameter int p_DST_BASE  = 'hFE00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             src_page,
  output logic                   busy,
  output logic                   done,
  input  logic                   mem_gnt,
  output logic [p_ADDR_BITS-1:0] mem_addr,
  output logic                   mem_ren,
  output logic                   mem_wen,
  output logic [p_DATA_BITS-1:0] mem_data,
  input  logic [p_DATA_BITS-1:0] mem_q
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] CAP  = 2'd2;
  localparam logic [1:0] WR   = 2'd3;

  logic [1:0]             state;
  logic [7:0]             idx;
  logic [7:0]             src_page_r;
  logic [p_DATA_BITS-1:0] data_r;
  logic                   done_r;
  logic                   last;
  logic                   restart;

  assign last = (idx == 8'(p_LEN - 1));

  // A start while busy either restarts the transfer or is dropped.
`ifdef DMG_DMA_RESTART_EN
  assign restart = start && (state != IDLE);
`else
  assign restart = 1'b0;
`endif

  // Sequencer: read one byte, capture it, write it, advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 8'd0;
      src_page_r <= 8'd0;
      data_r     <= '0;
      done_r     <= 1'b0;
    end else begin
      done_r <= (state == WR) && mem_gnt && last;
      if (restart || (state == IDLE && start)) begin
        src_page_r <= src_page;
        idx        <= 8'd0;
        state      <= RD;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          RD: begin
            if (mem_gnt) state <= CAP;
          end
          CAP: begin
            data_r <= mem_q;
            state  <= WR;
          end
          WR: begin
            if (mem_gnt) begin
              if (last) begin
                state <= IDLE;
              end else begin
                idx   <= idx + 8'd1;
                state <= RD;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Bus outputs decode from state; reset silences them in the same cycle.
  always_comb begin
    mem_addr = '0;
    mem_ren  = 1'b0;
    mem_wen  = 1'b0;
    mem_data = '0;
    busy     = 1'b0;
    done     = 1'b0;
    if (!rst) begin
      busy = (state != IDLE);
      done = done_r;
      case (state)
        RD: begin
          mem_addr = p_ADDR_BITS'({src_page_r, 8'h00}) + p_ADDR_BITS'(idx);
          mem_ren  = mem_gnt;
        end
        WR: begin
          mem_addr = p_ADDR_BITS'(p_DST_BASE) + p_ADDR_BITS'(idx);
          mem_data = data_r;
          mem_wen  = mem_gnt;
        end
        default: begin
          mem_addr = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gb_oam_dma.sv
// tb/tb_gb_oam_dma.sv - randomized self-checking bench for gb_oam_dma against a transaction-queue model
module tb_gb_oam_dma;

  localparam int LEN = 160;
`ifdef DMG_DMA_RESTART_EN
  localparam bit restart_en = 1'b1;
`else
  localparam bit restart_en = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  src_page = 8'h00;
  logic        busy, done;
  logic        mem_gnt = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_ren, mem_wen;
  logic [7:0]  mem_data;
  logic [7:0]  mem_q = 8'h00;

  gb_oam_dma dut (
    .clk(clk), .rst(rst), .start(start), .src_page(src_page),
    .busy(busy), .done(done), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_data(mem_data), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Expected memory image: distinct pattern per source page, 0xEE elsewhere.
  function automatic logic [7:0] src_val(input logic [15:0] a);
    logic [7:0] t;
    t = a[7:0];
    case (a[15:8])
      8'hC0:   return t ^ 8'h5A;
      8'hD0:   return ~t;
      8'hFF:   return t * 8'd3;
      default: return 8'hEE;
    endcase
  endfunction

  // 1-cycle-latency synchronous memory, refillable to the pattern.
  logic [7:0] mem [0:65535];
  logic       fill = 1'b0;
  always @(posedge clk) begin
    if (fill) begin
      for (int a = 0; a < 65536; a++) mem[a] <= src_val(16'(a));
    end else begin
      if (mem_ren) mem_q <= mem[mem_addr];
      if (mem_wen) mem[mem_addr] <= mem_data;
    end
  end

  // Grant: always-on or 50% random.
  bit rnd_gnt = 1'b0;
  always @(posedge clk) begin
    #1;
    mem_gnt = rnd_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          w;
    logic [15:0] a;
    logic [7:0]  d;
    bit          last;
  } acc_t;

  acc_t        q[$];
  acc_t        e;
  bit          active = 1'b0;
  bit          exp_done = 1'b0;
  bit          nd, na;
  int          wr_cnt = 0;
  int          busy_cyc = 0;
  int          done_cnt = 0;
  logic [15:0] max_rd = 16'h0000;

  // A transfer is the ordered list: read src+i, write dst+i with src byte.
  task automatic build(input logic [7:0] p);
    acc_t t;
    q.delete();
    for (int i = 0; i < LEN; i++) begin
      t.w = 1'b0; t.a = {p, 8'h00} + 16'(i); t.d = 8'h00; t.last = 1'b0;
      q.push_back(t);
      t.w = 1'b1; t.a = 16'hFE00 + 16'(i); t.d = src_val({p, 8'h00} + 16'(i));
      t.last = (i == LEN - 1);
      q.push_back(t);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", {busy, done, mem_ren, mem_wen, mem_addr, mem_data}, 0);
      active   = 1'b0;
      exp_done = 1'b0;
      q.delete();
    end else begin
      chk("busy", busy, active);
      chk("done", done, exp_done);
      if (done) done_cnt++;
      if (busy) busy_cyc++;
      chk("ren_wen_exclusive", mem_ren && mem_wen, 0);
      if (mem_ren || mem_wen) chk("access_needs_gnt", mem_gnt, 1);
      if (!active) chk("idle_mem_zero", {mem_ren, mem_wen, mem_addr, mem_data}, 0);
      nd = 1'b0;
      na = active;
      if (mem_ren || mem_wen) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_access: got access at 0x%0h expected none", mem_addr);
        end else begin
          e = q.pop_front();
          chk("acc_kind", mem_wen, e.w);
          chk("acc_addr", mem_addr, e.a);
          if (e.w) begin
            chk("wr_data", mem_data, e.d);
            wr_cnt++;
            if (e.last) begin
              nd = 1'b1;
              na = 1'b0;
            end
          end else if (mem_addr > max_rd) begin
            max_rd = mem_addr;
          end
        end
      end
      if (start && (!active || restart_en)) begin
        na = 1'b1;
        build(src_page);
      end
      active   = na;
      exp_done = nd;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fill();
    fill = 1'b1;
    cyc();
    fill = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] p);
    start    = 1'b1;
    src_page = p;
    cyc();
    start    = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < budget && done_cnt == d0; k++) cyc();
    chk({nm, "_done_pulses"}, done_cnt - d0, 1);
    repeat (2) cyc();
  endtask

  task automatic wait_writes(input int w0, input int n, input string nm);
    for (int k = 0; k < 5000 && (wr_cnt - w0) < n; k++) cyc();
    chk({nm, "_writes_reached"}, wr_cnt - w0, n);
  endtask

  task automatic check_oam(input logic [7:0] p, input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < LEN; i++)
      if (mem[16'hFE00 + 16'(i)] != src_val({p, 8'h00} + 16'(i))) bad++;
    chk({nm, "_oam_bad_bytes"}, bad, 0);
  endtask

  int b0, d0, w0;

  initial begin
    rst = 1'b1;
    repeat (3) cyc();
    do_fill();
    rst = 1'b0;
    cyc();
    chk("post_reset_busy", busy, 0);

    // Full-grant copy from 0xC0: 480 busy cycles, known end bytes.
    b0 = busy_cyc;
    do_start(8'hC0);
    wait_done(2000, "t1");
    chk("t1_busy_cycles", busy_cyc - b0, 480);
    check_oam(8'hC0, "t1");
    chk("t1_fe00", mem[16'hFE00], 8'h5A);
    chk("t1_fe9f", mem[16'hFE9F], 8'hC5);

    // Random grant copy from 0xD0.
    rnd_gnt = 1'b1;
    do_fill();
    do_start(8'hD0);
    wait_done(5000, "t2");
    check_oam(8'hD0, "t2");
    chk("t2_fe10", mem[16'hFE10], 8'hEF);

    // Top page: last source address must be 0xFF9F.
    do_fill();
    max_rd = 16'h0000;
    do_start(8'hFF);
    wait_done(5000, "t3");
    chk("t3_last_src", max_rd, 16'hFF9F);
    check_oam(8'hFF, "t3");

    // Reset at idx=50 aborts with no done and no further writes.
    rnd_gnt = 1'b0;
    do_fill();
    w0 = wr_cnt;
    do_start(8'hC0);
    wait_writes(w0, 50, "t4");
    d0 = done_cnt;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (5) cyc();
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_fe32_untouched", mem[16'hFE32], 8'hEE);
    chk("t4_fe31_written", mem[16'hFE31], src_val(16'hC031));

    // Start at idx=80 with page 0xD0.
    do_fill();
    w0 = wr_cnt;
    b0 = busy_cyc;
    do_start(8'hC0);
    wait_writes(w0, 80, "t5");
    start = 1'b1;
    src_page = 8'hD0;
    cyc();
    start = 1'b0;
    wait_done(5000, "t5");
    chk("t5_busy_cycles", busy_cyc - b0, restart_en ? 721 : 480);
    check_oam(restart_en ? 8'hD0 : 8'hC0, "t5");

    // Start coincident with the final write.
    do_fill();
    d0 = done_cnt;
    do_start(8'hC0);
    repeat (479) cyc();
    start = 1'b1;
    src_page = 8'hD0;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 2000 && busy; k++) cyc();
    repeat (3) cyc();
    chk("t6_done_pulses", done_cnt - d0, restart_en ? 2 : 1);
    check_oam(restart_en ? 8'hD0 : 8'hC0, "t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
